// File: rtl/bullet_pool.sv
// Player-bullet pool.
// Fires multi-lane volleys into the lowest free slot on a fixed period and moves live slots
// upward on a divided tick. Individual lanes are cleared by hits, and per-pixel occupancy
// queries are answered for the renderer with one cycle of latency.
module bullet_pool #(
    parameter int unsigned SLOT_NUM    = 8,
    parameter int unsigned LANE_NUM    = 3,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned FIRE_PERIOD = 1000,
    parameter int unsigned MOVE_DIV    = 4,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned X_OFFSET    = 0,
    parameter int unsigned Y_OFFSET    = 0,
    parameter int unsigned LANE_PITCH  = 16,
    parameter int unsigned BULLET_W    = 4,
    parameter int unsigned BULLET_H    = 8,
    localparam int unsigned SLOT_W     = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1,
    localparam int unsigned LANE_W     = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1,
    localparam int unsigned CNT_W      = $clog2(SLOT_NUM + 1)
) (
    input  logic                clk_run,
    input  logic                rst,
    input  logic                en_i,
    input  logic [LANE_NUM-1:0] lane_mask_i,
    input  logic [X_W-1:0]      me_x_pos_i,
    input  logic [Y_W-1:0]      me_y_pos_i,
    input  logic                hit_valid_i,
    input  logic [SLOT_W-1:0]   hit_slot_i,
    input  logic [LANE_W-1:0]   hit_lane_i,
    input  logic                query_valid_i,
    input  logic [X_W-1:0]      query_x_i,
    input  logic [Y_W-1:0]      query_y_i,
    output logic                query_hit_o,
    output logic [SLOT_W-1:0]   query_slot_o,
    output logic [LANE_W-1:0]   query_lane_o,
    output logic                fire_o,
    output logic [CNT_W-1:0]    active_cnt_o,
    output logic [7:0]          drop_cnt_o
);

    localparam int unsigned FIRE_W = $clog2(FIRE_PERIOD);
    localparam int unsigned MOVE_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_PERIOD - 1);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_DIV - 1);

    logic [X_W-1:0]      x_q    [SLOT_NUM];
    logic [X_W-1:0]      x_d    [SLOT_NUM];
    logic [Y_W-1:0]      y_q    [SLOT_NUM];
    logic [Y_W-1:0]      y_d    [SLOT_NUM];
    logic [LANE_NUM-1:0] live_q [SLOT_NUM];
    logic [LANE_NUM-1:0] live_d [SLOT_NUM];

    logic [FIRE_W-1:0] fire_cnt_q, fire_cnt_d;
    logic [MOVE_W-1:0] move_cnt_q, move_cnt_d;
    logic              fire_q, fire_d;
    logic [7:0]        drop_q, drop_d;
    logic [CNT_W-1:0]  active_q, active_d;
    logic              qhit_q, qhit_d;
    logic [SLOT_W-1:0] qslot_q, qslot_d;
    logic [LANE_W-1:0] qlane_q, qlane_d;

    logic              fire_try, move_tick;
    logic              free_found, do_alloc, do_drop;
    logic [SLOT_W-1:0] free_idx;
    logic [LANE_NUM-1:0] hit_clr;
    logic [X_W:0]      lane_x, qx;
    logic [Y_W:0]      slot_y, qy;

    // Fire and move timers advance only while enabled; terminal counts raise the strobes.
    always_comb begin
        fire_cnt_d = fire_cnt_q;
        move_cnt_d = move_cnt_q;
        fire_try   = 1'b0;
        move_tick  = 1'b0;
        if (en_i) begin
            if (fire_cnt_q == FIRE_LAST) begin
                fire_cnt_d = '0;
                fire_try   = 1'b1;
            end else begin
                fire_cnt_d = fire_cnt_q + 1'b1;
            end
            if (move_cnt_q == MOVE_LAST) begin
                move_cnt_d = '0;
                move_tick  = 1'b1;
            end else begin
                move_cnt_d = move_cnt_q + 1'b1;
            end
        end
    end

    // Lowest-index free slot; descending scan so the smallest index is written last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int s = int'(SLOT_NUM) - 1; s >= 0; s--) begin
            if (live_q[s] == '0) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(s);
            end
        end
        do_alloc = fire_try && (lane_mask_i != '0) && free_found;
        do_drop  = fire_try && (lane_mask_i != '0) && !free_found;
    end

    // Per-slot next state: allocation overrides hit and move; hit and move may combine.
    always_comb begin
        hit_clr  = '0;
        active_d = '0;
        if (32'(hit_lane_i) < LANE_NUM) begin
            hit_clr = LANE_NUM'(1) << hit_lane_i;
        end
        for (int s = 0; s < int'(SLOT_NUM); s++) begin
            x_d[s]    = x_q[s];
            y_d[s]    = y_q[s];
            live_d[s] = live_q[s];
            if (do_alloc && free_idx == SLOT_W'(s)) begin
                x_d[s]    = me_x_pos_i + X_W'(X_OFFSET);
                y_d[s]    = me_y_pos_i + Y_W'(Y_OFFSET);
                live_d[s] = lane_mask_i;
            end else begin
                if (hit_valid_i && hit_slot_i == SLOT_W'(s)) begin
                    live_d[s] = live_d[s] & ~hit_clr;
                end
                if (move_tick && live_q[s] != '0) begin
                    if (y_q[s] >= Y_W'(SPEED)) begin
                        y_d[s] = y_q[s] - Y_W'(SPEED);
                    end else begin
                        live_d[s] = '0;
                    end
                end
            end
            active_d = active_d + CNT_W'(live_d[s] != '0);
        end
    end

    // Fire pulse and saturating drop counter.
    always_comb begin
        fire_d = do_alloc;
        drop_d = drop_q;
        if (do_drop && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Pixel query against current state; descending scan leaves lowest slot/lane as winner.
    always_comb begin
        qhit_d  = 1'b0;
        qslot_d = '0;
        qlane_d = '0;
        lane_x  = '0;
        slot_y  = '0;
        qx      = {1'b0, query_x_i};
        qy      = {1'b0, query_y_i};
        if (query_valid_i) begin
            for (int s = int'(SLOT_NUM) - 1; s >= 0; s--) begin
                for (int l = int'(LANE_NUM) - 1; l >= 0; l--) begin
                    lane_x = {1'b0, x_q[s]} + (X_W + 1)'(l * LANE_PITCH);
                    slot_y = {1'b0, y_q[s]};
                    if (live_q[s][l] && qx >= lane_x && qx < lane_x + (X_W + 1)'(BULLET_W)
                        && qy >= slot_y && qy < slot_y + (Y_W + 1)'(BULLET_H)) begin
                        qhit_d  = 1'b1;
                        qslot_d = SLOT_W'(s);
                        qlane_d = LANE_W'(l);
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SLOT_NUM); s++) begin
                x_q[s]    <= '0;
                y_q[s]    <= '0;
                live_q[s] <= '0;
            end
            fire_cnt_q <= '0;
            move_cnt_q <= '0;
            fire_q     <= 1'b0;
            drop_q     <= '0;
            active_q   <= '0;
            qhit_q     <= 1'b0;
            qslot_q    <= '0;
            qlane_q    <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            live_q     <= live_d;
            fire_cnt_q <= fire_cnt_d;
            move_cnt_q <= move_cnt_d;
            fire_q     <= fire_d;
            drop_q     <= drop_d;
            active_q   <= active_d;
            qhit_q     <= qhit_d;
            qslot_q    <= qslot_d;
            qlane_q    <= qlane_d;
        end
    end

    assign query_hit_o  = qhit_q;
    assign query_slot_o = qslot_q;
    assign query_lane_o = qlane_q;
    assign fire_o       = fire_q;
    assign active_cnt_o = active_q;
    assign drop_cnt_o   = drop_q;

endmodule
